serial_subtractor_4bits: RTL and testbench

Bit-serial subtractor, the inverse-direction companion to the 4-bit ripple adder. It computes Diff = A - B - Bin, one bit per clock, LSB first, using a single borrow flip-flop. A start/busy/done handshake lets a controller or bench launch one operation and collect the result. The block is for datapaths that trade area for latency.

---
 rtl/serial_subtractor_4bits_pkg.sv | 14 +
 rtl/full_subtractor_1bit.sv | 16 +
 rtl/serial_subtractor_4bits.sv | 132 +++++++++++++
 tb/tb_serial_subtractor_4bits.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_4bits_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and
// default operand/counter widths.
package serial_subtractor_4bits_pkg;

  // FSM state encoding (kept as plain constants for legacy compatibility)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Default operand width and matching bit-counter width
  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned DEFAULT_CNT_W = 3;

endpackage

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Borrow is raised when a < b + bin for this bit position.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor_4bits.sv
// Bit-serial subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// A single full subtractor plus a borrow flip-flop does all the arithmetic;
// operands are captured on start and shifted right, result bits shift in
// from the MSB end. Diff/Bout are only updated on the edge entering DONE.
module serial_subtractor_4bits
  import serial_subtractor_4bits_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             fs_d;
  logic             fs_bout;
  logic [WIDTH-1:0] res_shifted;

  // Current bit is always the LSB of the shifting operand registers.
  full_subtractor_1bit u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // New difference bit enters at the MSB; after WIDTH shifts bit 0 is the LSB result.
  assign res_shifted = {fs_d, res_q[WIDTH-1:1]};

  // Next-state logic for FSM, counter, operand/result shifters and borrow FF.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          br_d    = Bin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = fs_bout;
        res_d = res_shifted;
        if (cnt_q == LAST_BIT) begin
          // Publish the full result only now so partial shifts stay hidden.
          diff_d  = res_shifted;
          bout_d  = fs_bout;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        // Unused encoding: recover to a clean idle.
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous, active-high reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  // Status and result outputs decode directly from registered state.
  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
    Diff = diff_q;
    Bout = bout_q;
  end

endmodule

// File: tb/tb_serial_subtractor_4bits.sv
// Scoreboard bench for serial_subtractor_4bits: stimulus pushes expected
// {Bout, Diff} into a queue, a monitor pops and compares on every done.
module tb_serial_subtractor_4bits;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       Bin;
  logic       busy;
  logic       done;
  logic [3:0] Diff;
  logic       Bout;

  logic [4:0] sb[$];
  int         n_checks;
  int         n_pass;
  int         cyc;
  logic       prev_done;

  serial_subtractor_4bits #(
    .WIDTH (4),
    .CNT_W (3)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
    .Bout  (Bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compare result against scoreboard whenever done is presented.
  always @(negedge clk) begin
    if (done) begin
      chk("done_width", 32'(prev_done), 32'd0);
      if (sb.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        logic [4:0] e;
        e = sb.pop_front();
        chk("result", 32'({Bout, Diff}), 32'(e));
      end
    end
    prev_done <= done;
  end

  // Launch one operation and wait (bounded) for its done pulse.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                        input logic [4:0] exp, input bit timing);
    int lat;
    int nbusy;
    bit got;
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    A = ~a; B = ~b; Bin = ~bin;
    lat = 0; nbusy = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
      if (done) got = 1'b1;
    end
    if (timing) begin
      chk("latency", 32'(lat), 32'd5);
      chk("busy_cycles", 32'(nbusy), 32'd4);
    end else if (!got) begin
      chk("done_timeout", 32'(got), 32'd1);
    end
  endtask

  initial begin
    int  ndone;
    int  t1;
    int  t2;
    bit  changed;
    n_checks = 0; n_pass = 0; cyc = 0; prev_done = 1'b0;
    rst = 1'b1; start = 1'b0; A = 4'd0; B = 4'd0; Bin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_diff", 32'(Diff), 32'd0);
    chk("reset_bout", 32'(Bout), 32'd0);

    // Directed vectors, hand-computed {Bout, Diff}
    run_op(4'd9,  4'd3,  1'b0, {1'b0, 4'd6},  1'b1);
    repeat (3) @(negedge clk);
    chk("hold_diff", 32'(Diff), 32'd6);
    chk("hold_busy", 32'(busy), 32'd0);
    run_op(4'd3,  4'd5,  1'b0, {1'b1, 4'd14}, 1'b1);
    run_op(4'd0,  4'd0,  1'b1, {1'b1, 4'd15}, 1'b1);
    run_op(4'd15, 4'd15, 1'b1, {1'b1, 4'd15}, 1'b1);
    run_op(4'd7,  4'd7,  1'b0, {1'b0, 4'd0},  1'b1);
    run_op(4'd12, 4'd5,  1'b0, {1'b0, 4'd7},  1'b1);

    // start held high; operands change while running
    @(negedge clk);
    A = 4'd10; B = 4'd4; Bin = 1'b1; start = 1'b1;
    sb.push_back({1'b0, 4'd5});
    @(posedge clk);
    #1;
    A = 4'd2; B = 4'd9; Bin = 1'b0;
    sb.push_back({1'b1, 4'd9});
    ndone = 0; t1 = 0; t2 = 0; changed = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 1) t1 = cyc;
        else t2 = cyc;
      end
      if (ndone == 1 && busy && !changed) begin
        A = 4'd15; B = 4'd0; Bin = 1'b1;
        changed = 1'b1;
      end
      if (ndone == 2) begin
        start = 1'b0;
        break;
      end
    end
    chk("held_done_count", 32'(ndone), 32'd2);
    chk("held_done_spacing", 32'(t2 - t1), 32'd6);
    @(negedge clk);
    @(negedge clk);
    chk("held_no_third", 32'(busy), 32'd0);

    // Reset on the second RUN cycle aborts without a done pulse
    @(negedge clk);
    A = 4'd13; B = 4'd2; Bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(Diff), 32'd0);
    chk("abort_bout", 32'(Bout), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    run_op(4'd13, 4'd2, 1'b0, {1'b0, 4'd11}, 1'b1);

    // Exhaustive sweep against the 5-bit two's complement model
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          int r;
          r = a - b - c;
          run_op(4'(a), 4'(b), 1'(c), 5'(r), 1'b0);
        end
      end
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
